// File: rtl/registrador_universal.sv
// Universal WIDTH-bit shift register: hold / shift right / shift left / load,
// registered serial output and a word counter. Optional feedback: REG_ROTATE_EN.
module registrador_universal #(
  parameter int WIDTH = 4,
  parameter int CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [1:0]       Mode,
  input  logic             Shift_in_r,
  input  logic             Shift_in_l,
  input  logic [WIDTH-1:0] Load_data,
  input  logic             Rotate,
  output logic [WIDTH-1:0] Q,
  output logic             shift_out,
  output logic [CW-1:0]    Count,
  output logic             word_done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_shift_out;
  logic [CW-1:0]    r_count;
  logic             r_word_done;

  logic             w_rot;
  logic             w_in_r;
  logic             w_in_l;
  logic             w_last;
  mode_e            w_mode;

  assign w_mode = mode_e'(Mode);

`ifdef REG_ROTATE_EN
  assign w_rot = Rotate;
`else
  // Port kept for drop-in compatibility; no feedback path is built.
  assign w_rot = 1'b0 & Rotate;
`endif

  assign w_in_r = w_rot ? r_q[0]       : Shift_in_r;
  assign w_in_l = w_rot ? r_q[WIDTH-1] : Shift_in_l;
  assign w_last = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_q         <= '0;
      r_shift_out <= 1'b0;
      r_count     <= '0;
      r_word_done <= 1'b0;
    end else begin
      unique case (w_mode)
        MODE_HOLD: begin
          r_word_done <= 1'b0;
        end
        MODE_RIGHT: begin
          r_q         <= {w_in_r, r_q[WIDTH-1:1]};
          r_shift_out <= r_q[0];
          r_count     <= w_last ? '0 : r_count + 1'b1;
          r_word_done <= w_last;
        end
        MODE_LEFT: begin
          r_q         <= {r_q[WIDTH-2:0], w_in_l};
          r_shift_out <= r_q[WIDTH-1];
          r_count     <= w_last ? '0 : r_count + 1'b1;
          r_word_done <= w_last;
        end
        MODE_LOAD: begin
          r_q         <= Load_data;
          r_count     <= '0;
          r_word_done <= 1'b0;
        end
        default: begin
          r_word_done <= 1'b0;
        end
      endcase
    end
  end

  assign Q         = r_q;
  assign shift_out = r_shift_out;
  assign Count     = r_count;
  assign word_done = r_word_done;

endmodule

// File: tb/tb_registrador_universal.sv
// Directed bench for registrador_universal at WIDTH=4 with hand-computed expectations.
module tb_registrador_universal;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [1:0] Mode;
  logic       Shift_in_r;
  logic       Shift_in_l;
  logic [3:0] Load_data;
  logic       Rotate;
  logic [3:0] Q;
  logic       shift_out;
  logic [1:0] Count;
  logic       word_done;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  registrador_universal #(.WIDTH(4)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Mode       (Mode),
    .Shift_in_r (Shift_in_r),
    .Shift_in_l (Shift_in_l),
    .Load_data  (Load_data),
    .Rotate     (Rotate),
    .Q          (Q),
    .shift_out  (shift_out),
    .Count      (Count),
    .word_done  (word_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic rst, input logic [1:0] m, input logic sr,
                      input logic sl, input logic [3:0] ld, input logic rot);
    Reset = rst; Mode = m; Shift_in_r = sr; Shift_in_l = sl; Load_data = ld; Rotate = rot;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] q, input logic so,
                         input logic [1:0] c, input logic wd);
    chk({tag, ".Q"}, 32'(Q), 32'(q));
    chk({tag, ".shift_out"}, 32'(shift_out), 32'(so));
    chk({tag, ".Count"}, 32'(Count), 32'(c));
    chk({tag, ".word_done"}, 32'(word_done), 32'(wd));
  endtask

  initial begin
    Reset = 1'b0; Mode = 2'b00; Shift_in_r = 1'b0; Shift_in_l = 1'b0;
    Load_data = 4'h0; Rotate = 1'b0;
    @(negedge CLK);

    // 1. reset beats load
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b0);
    chk_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);

    // 2. serialize
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1011, 1'b0);
    chk_all("ser_load", 4'b1011, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'b0, 1'b0);
    chk_all("ser1", 4'b0101, 1'b1, 2'd1, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'b0, 1'b0);
    chk_all("ser2", 4'b0010, 1'b1, 2'd2, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'b0, 1'b0);
    chk_all("ser3", 4'b0001, 1'b0, 2'd3, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'b0, 1'b0);
    chk_all("ser4", 4'b0000, 1'b1, 2'd0, 1'b1);

    // 3. deserialize with a pause
    step(1'b0, 2'b10, 1'b0, 1'b1, 4'b0, 1'b0);
    chk_all("des1", 4'b0001, 1'b0, 2'd1, 1'b0);
    step(1'b0, 2'b10, 1'b0, 1'b0, 4'b0, 1'b0);
    chk_all("des2", 4'b0010, 1'b0, 2'd2, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b1, 4'b0, 1'b0);
    chk_all("des_hold1", 4'b0010, 1'b0, 2'd2, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b1, 4'b0, 1'b0);
    chk_all("des_hold2", 4'b0010, 1'b0, 2'd2, 1'b0);
    step(1'b0, 2'b10, 1'b0, 1'b1, 4'b0, 1'b0);
    chk_all("des3", 4'b0101, 1'b0, 2'd3, 1'b0);
    step(1'b0, 2'b10, 1'b0, 1'b1, 4'b0, 1'b0);
    chk_all("des4", 4'b1011, 1'b0, 2'd0, 1'b1);

    // load right after a word clears the pulse and keeps shift_out
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1010, 1'b0);
    chk_all("load_after_word", 4'b1010, 1'b0, 2'd0, 1'b0);

    // 4. back-to-back words: pulse only after edges 4 and 8
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 2'b01, 1'b1, 1'b0, 4'b0, 1'b0);
      chk($sformatf("b2b%0d.word_done", i), 32'(word_done), 32'((i % 4) == 0));
      chk($sformatf("b2b%0d.Count", i), 32'(Count), 32'(i % 4));
    end
    chk("b2b.Q", 32'(Q), 32'(4'b1111));

    // 5. rotate
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1001, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'b0, 1'b1);
`ifdef REG_ROTATE_EN
    chk_all("rotate", 4'b1100, 1'b1, 2'd1, 1'b0);
`else
    chk_all("rotate", 4'b0100, 1'b1, 2'd1, 1'b0);
`endif

    // 6. reset mid-word
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'b0, 1'b0);
    chk_all("mid1", 4'b0111, 1'b1, 2'd1, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'b0, 1'b0);
    chk_all("mid2", 4'b0011, 1'b1, 2'd2, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 4'b0, 1'b0);
    chk_all("mid_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'b0, 1'b0);
    chk_all("post1", 4'b1000, 1'b0, 2'd1, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'b0, 1'b0);
    chk_all("post2", 4'b1100, 1'b0, 2'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
